// File: rtl/multicycle_control.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// multicycle_control
// Control FSM for a multicycle RISC-V style datapath. It sequences instruction
// fetch, decode, execute, memory access and writeback. It also watches every
// memory handshake with a wait counter that ends in a trap on timeout.
//
// Parameters
//   MEM_TIMEOUT  maximum cycles to wait for mem_ready (1..255)
//
// Optional feature
//   MULTICYCLE_CONTROL_PERF_EN  when defined, builds a 32-bit retired-
//                               instruction counter. Otherwise retire_count
//                               is tied to 0.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   opcode[6:0]       instruction register opcode field
//   alu_zero          ALU zero flag (branch condition)
//   mem_ready         memory completes the current access this cycle
//   mem_req/mem_we    memory request / write qualifier
//   mem_addr_sel      memory address source: 0 PC, 1 ALU result register
//   ir_write          latch instruction register
//   pc_write, pc_src  PC update strobe and source (0 PC+4, 1 branch target)
//   alu_op[1:0]       00 add, 01 subtract/compare, 10 funct-decoded
//   alu_src_a         0 PC, 1 rs1
//   alu_src_b[1:0]    00 rs2, 01 constant 4, 10 immediate
//   reg_write         register file write strobe
//   mem_to_reg        writeback source: 0 ALU, 1 memory data
//   illegal, bus_err  sticky error flags, cleared only by reset
//   state_o[3:0]      current state encoding
//   retire_count[31:0] retired-instruction counter
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic [1:0]  alu_op,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic        bus_err,
    output logic [3:0]  state_o,
    output logic [31:0] retire_count
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_ALU   = 4'd7,
        WB_MEM   = 4'd8,
        BRANCH   = 4'd9,
        TRAP     = 4'd10
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // The timeout fires in the cycle the counter would step onto MEM_TIMEOUT.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        illegal_q, illegal_d;
    logic        bus_err_q, bus_err_d;
    logic        started_q;
    logic        wait_inc_s;

    // Run flag: keeps every strobe low from reset until the first clock edge
    // after release, so reset drops mem_req immediately and the first fetch
    // request is fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started_q <= 1'b0;
        end else begin
            started_q <= 1'b1;
        end
    end

    // State, wait counter and sticky error flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            wait_q    <= 8'd0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        illegal_d    = illegal_q;
        bus_err_d    = bus_err_q;
        wait_inc_s   = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        alu_op       = 2'b00;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;

        case (state_q)
            FETCH: begin
                if (started_q) begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = DECODE;
                    end else if (wait_q == WAIT_LAST) begin
                        state_d   = TRAP;
                        bus_err_d = 1'b1;
                    end else begin
                        wait_inc_s = 1'b1;
                    end
                end else begin
                    state_d = FETCH;
                end
            end
            DECODE: begin
                // ALU precomputes PC + imm as the branch target.
                alu_src_b = 2'b10;
                case (opcode)
                    OP_R:      state_d = EXEC_R;
                    OP_I:      state_d = EXEC_I;
                    OP_LOAD:   state_d = MEM_ADDR;
                    OP_STORE:  state_d = MEM_ADDR;
                    OP_BRANCH: state_d = BRANCH;
                    default: begin
                        state_d   = TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
                alu_op    = 2'b10;
                state_d   = WB_ALU;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b10;
                state_d   = WB_ALU;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // Opcode is looked at again here; anything that is no longer
                // a load or store is treated as illegal.
                if (opcode == OP_LOAD) begin
                    state_d = MEM_RD;
                end else if (opcode == OP_STORE) begin
                    state_d = MEM_WR;
                end else begin
                    state_d   = TRAP;
                    illegal_d = 1'b1;
                end
            end
            MEM_RD, MEM_WR: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (state_q == MEM_WR);
                if (mem_ready) begin
                    state_d = (state_q == MEM_WR) ? FETCH : WB_MEM;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    wait_inc_s = 1'b1;
                end
            end
            WB_ALU: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
                alu_op    = 2'b01;
                pc_src    = 1'b1;
                pc_write  = alu_zero;
                state_d   = FETCH;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                // Unreachable encodings fall into the trap.
                state_d = TRAP;
            end
        endcase

        // The wait counter restarts on every state change, so each memory
        // state is entered with a count of zero.
        if (state_d != state_q) begin
            wait_d = 8'd0;
        end else if (wait_inc_s) begin
            wait_d = wait_q + 8'd1;
        end else begin
            wait_d = wait_q;
        end
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign state_o = state_q;

`ifdef MULTICYCLE_CONTROL_PERF_EN
    logic [31:0] retire_q;
    logic        retire_s;

    // An instruction retires as it leaves its final state.
    assign retire_s = (state_q == WB_ALU) || (state_q == WB_MEM) ||
                      (state_q == BRANCH) || ((state_q == MEM_WR) && mem_ready);

    // Retired-instruction counter, wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_q <= 32'd0;
        end else if (retire_s) begin
            retire_q <= retire_q + 32'd1;
        end else begin
            retire_q <= retire_q;
        end
    end

    assign retire_count = retire_q;
`else
    assign retire_count = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
`timescale 1ns/1ps
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic        alu_zero;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src;
    logic [1:0]  alu_op, alu_src_b;
    logic        alu_src_a, reg_write, mem_to_reg, illegal, bus_err;
    logic [3:0]  state_o;
    logic [31:0] retire_count;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] OP_ADD = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    multicycle_control #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_op(alu_op), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .illegal(illegal), .bus_err(bus_err), .state_o(state_o),
        .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    // Reset, release on a falling edge, return in the first running FETCH cycle.
    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        alu_zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_fetch(input logic [6:0] op);
        opcode = op;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (state_o !== 4'd0 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr_sel !== 1'b0 ||
            ir_write !== 1'b1 || pc_write !== 1'b1 || pc_src !== 1'b0 || alu_src_a !== 1'b0 ||
            alu_src_b !== 2'b01 || alu_op !== 2'b00 || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL fetch: state=%0d req=%b we=%b sel=%b ir=%b pcw=%b src=%b a=%b b=%b op=%b rw=%b, expected 0 1 0 0 1 1 0 0 01 00 0",
                     state_o, mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op, reg_write);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (state_o !== 4'd1 || mem_req !== 1'b0 || ir_write !== 1'b0 || pc_write !== 1'b0 ||
            alu_src_a !== 1'b0 || alu_src_b !== 2'b10 || alu_op !== 2'b00 || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL decode: state=%0d req=%b ir=%b pcw=%b a=%b b=%b op=%b rw=%b, expected 1 0 0 0 0 10 00 0",
                     state_o, mem_req, ir_write, pc_write, alu_src_a, alu_src_b, alu_op, reg_write);
        end
        @(negedge clk);
    endtask

    task automatic run_alu(input logic [6:0] op, input logic [3:0] exec_state, input logic [1:0] exp_b);
        run_fetch(op);
        #1;
        checks++;
        if (state_o !== exec_state || alu_src_a !== 1'b1 || alu_src_b !== exp_b ||
            alu_op !== 2'b10 || reg_write !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL exec: state=%0d a=%b b=%b op=%b rw=%b req=%b, expected %0d 1 %b 10 0 0",
                     state_o, alu_src_a, alu_src_b, alu_op, reg_write, mem_req, exec_state, exp_b);
        end
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 4'd7 || reg_write !== 1'b1 || mem_to_reg !== 1'b0) begin
            errors++;
            $display("FAIL wb_alu: state=%0d rw=%b m2r=%b, expected 7 1 0", state_o, reg_write, mem_to_reg);
        end
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 4'd0 || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL alu_return: state=%0d rw=%b, expected 0 0", state_o, reg_write);
        end
    endtask

    task automatic run_mem_addr();
        #1;
        checks++;
        if (state_o !== 4'd4 || alu_src_a !== 1'b1 || alu_src_b !== 2'b10 || alu_op !== 2'b00 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL mem_addr: state=%0d a=%b b=%b op=%b req=%b, expected 4 1 10 00 0",
                     state_o, alu_src_a, alu_src_b, alu_op, mem_req);
        end
        @(negedge clk);
    endtask

    task automatic run_load(input int waits);
        run_fetch(OP_LW);
        run_mem_addr();
        for (int w = 0; w <= waits; w++) begin
            mem_ready = (w == waits);
            #1;
            checks++;
            if (state_o !== 4'd5 || mem_req !== 1'b1 || mem_addr_sel !== 1'b1 || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL mem_rd[%0d]: state=%0d req=%b sel=%b we=%b, expected 5 1 1 0",
                         w, state_o, mem_req, mem_addr_sel, mem_we);
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #1;
        checks++;
        if (state_o !== 4'd8 || reg_write !== 1'b1 || mem_to_reg !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL wb_mem: state=%0d rw=%b m2r=%b req=%b, expected 8 1 1 0", state_o, reg_write, mem_to_reg, mem_req);
        end
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 4'd0 || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL load_return: state=%0d rw=%b, expected 0 0", state_o, reg_write);
        end
    endtask

    task automatic run_store();
        run_fetch(OP_SW);
        run_mem_addr();
        mem_ready = 1'b1;
        #1;
        checks++;
        if (state_o !== 4'd6 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr_sel !== 1'b1 || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL mem_wr: state=%0d req=%b we=%b sel=%b rw=%b, expected 6 1 1 1 0",
                     state_o, mem_req, mem_we, mem_addr_sel, reg_write);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (state_o !== 4'd0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL store_return: state=%0d we=%b, expected 0 0", state_o, mem_we);
        end
    endtask

    task automatic run_branch(input logic z);
        run_fetch(OP_BEQ);
        alu_zero = z;
        #1;
        checks++;
        if (state_o !== 4'd9 || pc_write !== z || pc_src !== 1'b1 || alu_op !== 2'b01 ||
            alu_src_a !== 1'b1 || alu_src_b !== 2'b00 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL branch(z=%b): state=%0d pcw=%b src=%b op=%b a=%b b=%b req=%b, expected 9 %b 1 01 1 00 0",
                     z, state_o, pc_write, pc_src, alu_op, alu_src_a, alu_src_b, mem_req, z);
        end
        @(negedge clk);
        alu_zero = 1'b0;
        #1;
        checks++;
        if (state_o !== 4'd0 || pc_src !== 1'b0) begin
            errors++;
            $display("FAIL branch_return: state=%0d src=%b, expected 0 0", state_o, pc_src);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        opcode = OP_ADD;
        alu_zero = 1'b0;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (state_o !== 4'd0 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr_sel !== 1'b0 ||
            ir_write !== 1'b0 || pc_write !== 1'b0 || pc_src !== 1'b0 || alu_op !== 2'b00 ||
            alu_src_a !== 1'b0 || alu_src_b !== 2'b00 || reg_write !== 1'b0 || mem_to_reg !== 1'b0 ||
            illegal !== 1'b0 || bus_err !== 1'b0 || retire_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: state=%0d req=%b ir=%b pcw=%b b=%b ill=%b berr=%b ret=%0d, expected all zero",
                     state_o, mem_req, ir_write, pc_write, alu_src_b, illegal, bus_err, retire_count);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || state_o !== 4'd0) begin
            errors++;
            $display("FAIL release_quiet: req=%b state=%0d, expected 0 0", mem_req, state_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b1 || state_o !== 4'd0 || mem_addr_sel !== 1'b0) begin
            errors++;
            $display("FAIL first_fetch: req=%b state=%0d sel=%b, expected 1 0 0", mem_req, state_o, mem_addr_sel);
        end
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        mem_ready = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || state_o !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_access: req=%b state=%0d, expected 0 0", mem_req, state_o);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b1 || state_o !== 4'd0) begin
            errors++;
            $display("FAIL refetch_after_reset: req=%b state=%0d, expected 1 0", mem_req, state_o);
        end
    endtask

    task automatic test_add();
        do_reset();
        run_alu(OP_ADD, 4'd2, 2'b00);
        run_alu(OP_ADDI, 4'd3, 2'b10);
    endtask

    task automatic test_load_store();
        do_reset();
        run_load(3);
        run_store();
    endtask

    task automatic test_branch();
        do_reset();
        run_branch(1'b1);
        run_branch(1'b0);
    endtask

    task automatic test_retire();
        logic [31:0] exp;
        do_reset();
        run_alu(OP_ADD, 4'd2, 2'b00);
        run_load(0);
        run_store();
        run_branch(1'b1);
        run_branch(1'b0);
`ifdef MULTICYCLE_CONTROL_PERF_EN
        exp = 32'd5;
`else
        exp = 32'd0;
`endif
        checks++;
        if (retire_count !== exp) begin
            errors++;
            $display("FAIL retire_count: got %0d, expected %0d", retire_count, exp);
        end
`ifdef MULTICYCLE_CONTROL_PERF_EN
        @(negedge clk);
        dut.retire_q = 32'hFFFF_FFFE;
        run_alu(OP_ADD, 4'd2, 2'b00);
        checks++;
        if (retire_count !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL retire_max: got %h, expected ffffffff", retire_count);
        end
        run_alu(OP_ADD, 4'd2, 2'b00);
        checks++;
        if (retire_count !== 32'd0) begin
            errors++;
            $display("FAIL retire_wrap: got %h, expected 00000000", retire_count);
        end
`endif
    endtask

    task automatic test_illegal();
        do_reset();
        run_fetch(OP_BAD);
        alu_zero = 1'b1;
        for (int i = 0; i < 20; i++) begin
            mem_ready = (i % 2 == 1);
            #1;
            checks++;
            if (state_o !== 4'd10 || illegal !== 1'b1 || bus_err !== 1'b0 || mem_req !== 1'b0 ||
                ir_write !== 1'b0 || pc_write !== 1'b0 || reg_write !== 1'b0) begin
                errors++;
                $display("FAIL trap_illegal[%0d]: state=%0d ill=%b berr=%b req=%b ir=%b pcw=%b rw=%b, expected 10 1 0 0 0 0 0",
                         i, state_o, illegal, bus_err, mem_req, ir_write, pc_write, reg_write);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (state_o !== 4'd0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_clear: state=%0d ill=%b, expected 0 0", state_o, illegal);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b0;
            #1;
            checks++;
            if (state_o !== 4'd0 || mem_req !== 1'b1 || bus_err !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait[%0d]: state=%0d req=%b berr=%b, expected 0 1 0", i, state_o, mem_req, bus_err);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (state_o !== 4'd10 || bus_err !== 1'b1 || illegal !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_trap: state=%0d berr=%b ill=%b req=%b, expected 10 1 0 0", state_o, bus_err, illegal, mem_req);
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            checks++;
            if (state_o !== 4'd0 || mem_req !== 1'b1 || bus_err !== 1'b0) begin
                errors++;
                $display("FAIL late_ready_wait[%0d]: state=%0d req=%b berr=%b, expected 0 1 0", i, state_o, mem_req, bus_err);
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #1;
        checks++;
        if (state_o !== 4'd1 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL late_ready_decode: state=%0d berr=%b, expected 1 0", state_o, bus_err);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_access();
        test_add();
        test_load_store();
        test_branch();
        test_retire();
        test_illegal();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
